// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry and the
// odd-parity helper that the transmitter also uses.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int DEFAULT_DATA_BITS  = 7;
    localparam int DEFAULT_OVERSAMPLE = 16;

    // Zero-extending a narrower word into the argument leaves the XOR reduction unchanged.
    function automatic logic odd_parity(input logic [31:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            q_o    <= 1'b1;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: start, DATA_BITS LSB-first, odd parity, stop, oversampled on rx_en.
// Define UART_RX_MAJORITY_EN to vote each bit 2-of-3 over the ticks around mid-bit.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rx_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int MID = OVERSAMPLE / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int VOTE_DELAY = 1;
`else
    localparam int VOTE_DELAY = 0;
`endif
    // Once the start decision clears the counter, every later decision lands one bit period on.
    localparam logic [TW-1:0] START_DECIDE = TW'(MID - 1 + VOTE_DELAY);
    localparam logic [TW-1:0] BIT_DECIDE   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT     = BW'(DATA_BITS - 1);

    rx_state_t              state_q;
    logic [TW-1:0]          tickCnt_q;
    logic [BW-1:0]          bitCnt_q;
    logic                   armed_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   parity_q;

    logic                   rxS;
    logic [TW-1:0]          decideTick;
    logic                   decideNow;
    logic                   bitVal;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rxS)
    );

    assign decideTick = (state_q == START) ? START_DECIDE : BIT_DECIDE;
    assign decideNow  = (tickCnt_q == decideTick);

`ifdef UART_RX_MAJORITY_EN
    logic vote1_q;
    logic vote2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vote1_q <= 1'b1;
            vote2_q <= 1'b1;
        end else if (rx_en) begin
            if (tickCnt_q == decideTick - TW'(2)) begin
                vote1_q <= rxS;
            end
            if (tickCnt_q == decideTick - TW'(1)) begin
                vote2_q <= rxS;
            end
        end
    end

    assign bitVal = (vote1_q & vote2_q) | (vote1_q & rxS) | (vote2_q & rxS);
`else
    assign bitVal = rxS;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tickCnt_q  <= '0;
            bitCnt_q   <= '0;
            armed_q    <= 1'b0;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (rx_en) begin
                unique case (state_q)
                    IDLE: begin
                        if (rxS) begin
                            armed_q <= 1'b1;
                        end else if (armed_q) begin
                            state_q   <= START;
                            tickCnt_q <= '0;
                            busy      <= 1'b1;
                        end
                    end
                    START: begin
                        if (decideNow) begin
                            tickCnt_q <= '0;
                            if (bitVal) begin
                                armed_q <= 1'b0;
                                busy    <= 1'b0;
                                state_q <= IDLE;
                            end else begin
                                bitCnt_q <= '0;
                                state_q  <= DATA;
                            end
                        end else begin
                            tickCnt_q <= tickCnt_q + TW'(1);
                        end
                    end
                    DATA: begin
                        if (decideNow) begin
                            tickCnt_q <= '0;
                            shreg_q   <= {bitVal, shreg_q[DATA_BITS-1:1]};
                            if (bitCnt_q == LAST_BIT) begin
                                state_q <= PARITY;
                            end else begin
                                bitCnt_q <= bitCnt_q + BW'(1);
                            end
                        end else begin
                            tickCnt_q <= tickCnt_q + TW'(1);
                        end
                    end
                    PARITY: begin
                        if (decideNow) begin
                            tickCnt_q <= '0;
                            parity_q  <= bitVal;
                            state_q   <= STOP;
                        end else begin
                            tickCnt_q <= tickCnt_q + TW'(1);
                        end
                    end
                    STOP: begin
                        if (decideNow) begin
                            // A low stop bit leaves us disarmed until the line is seen idle again.
                            tickCnt_q  <= '0;
                            bitCnt_q   <= '0;
                            data_out   <= shreg_q;
                            valid      <= 1'b1;
                            parity_err <= odd_parity(32'({shreg_q, parity_q}));
                            frame_err  <= ~bitVal;
                            busy       <= 1'b0;
                            armed_q    <= bitVal;
                            state_q    <= IDLE;
                        end else begin
                            tickCnt_q <= tickCnt_q + TW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: rx_en every 4th clk, OVERSAMPLE=16 (64 clk per bit).
// Build with UART_RX_MAJORITY_EN to add the mid-bit glitch scenario.
module tb_uart_receiver;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rx_en;
    logic [6:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    int         logCount = 0;
    logic [6:0] dataLog [16];
    logic       perrLog [16];
    logic       ferrLog [16];

    uart_receiver #(
        .OVERSAMPLE (16),
        .DATA_BITS  (7)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rx_en      (rx_en),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clk tick every fourth clock, changed on the falling edge.
    initial begin
        rx_en = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            rx_en = 1'b1;
            @(negedge clk);
            rx_en = 1'b0;
        end
    end

    // Every clk that valid is high is logged, so a stretched pulse shows up as an extra entry.
    always @(negedge clk) begin
        if (valid) begin
            dataLog[logCount % 16] = data_out;
            perrLog[logCount % 16] = parity_err;
            ferrLog[logCount % 16] = frame_err;
            logCount++;
        end
    end

    task automatic sendBit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [6:0] d, input logic par, input logic stp);
        sendBit(1'b0);
        for (int i = 0; i < 7; i++) sendBit(d[i]);
        sendBit(par);
        sendBit(stp);
    endtask

    task automatic test_reset;
        rx    = 1'b1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (data_out !== 7'h00) begin failures++; $display("[TB] FAIL reset_data: got %h expected 00", data_out); end
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_perr: got %b expected 0", parity_err); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_ferr: got %b expected 0", frame_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    task automatic test_good_frame;
        int base = logCount;
        sendFrame(7'h55, 1'b1, 1'b1);
        sendBit(1'b1);
        checks++; if (logCount - base !== 1) begin failures++; $display("[TB] FAIL good_valid_count: got %0d expected 1", logCount - base); end
        checks++; if (dataLog[base % 16] !== 7'h55) begin failures++; $display("[TB] FAIL good_data: got %h expected 55", dataLog[base % 16]); end
        checks++; if (perrLog[base % 16] !== 1'b0) begin failures++; $display("[TB] FAIL good_perr: got %b expected 0", perrLog[base % 16]); end
        checks++; if (ferrLog[base % 16] !== 1'b0) begin failures++; $display("[TB] FAIL good_ferr: got %b expected 0", ferrLog[base % 16]); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL good_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_parity_error;
        int base = logCount;
        sendFrame(7'h55, 1'b0, 1'b1);
        sendBit(1'b1);
        checks++; if (logCount - base !== 1) begin failures++; $display("[TB] FAIL perr_valid_count: got %0d expected 1", logCount - base); end
        checks++; if (dataLog[base % 16] !== 7'h55) begin failures++; $display("[TB] FAIL perr_data: got %h expected 55", dataLog[base % 16]); end
        checks++; if (perrLog[base % 16] !== 1'b1) begin failures++; $display("[TB] FAIL perr_flag: got %b expected 1", perrLog[base % 16]); end
        checks++; if (ferrLog[base % 16] !== 1'b0) begin failures++; $display("[TB] FAIL perr_ferr: got %b expected 0", ferrLog[base % 16]); end
        checks++; if (parity_err !== 1'b1) begin failures++; $display("[TB] FAIL perr_hold: got %b expected 1", parity_err); end
    endtask

    task automatic test_frame_error;
        int base = logCount;
        int busyHigh = 0;
        sendFrame(7'h12, 1'b1, 1'b0);
        checks++; if (logCount - base !== 1) begin failures++; $display("[TB] FAIL ferr_valid_count: got %0d expected 1", logCount - base); end
        checks++; if (dataLog[base % 16] !== 7'h12) begin failures++; $display("[TB] FAIL ferr_data: got %h expected 12", dataLog[base % 16]); end
        checks++; if (ferrLog[base % 16] !== 1'b1) begin failures++; $display("[TB] FAIL ferr_flag: got %b expected 1", ferrLog[base % 16]); end
        checks++; if (perrLog[base % 16] !== 1'b0) begin failures++; $display("[TB] FAIL ferr_perr: got %b expected 0", perrLog[base % 16]); end
        rx = 1'b0;
        repeat (2 * BIT_CLKS) begin
            @(negedge clk);
            if (busy) busyHigh++;
        end
        checks++; if (busyHigh !== 0) begin failures++; $display("[TB] FAIL ferr_no_start_busy: got %0d busy clks expected 0", busyHigh); end
        checks++; if (logCount - base !== 1) begin failures++; $display("[TB] FAIL ferr_no_spurious_valid: got %0d expected 1", logCount - base); end
        checks++; if (frame_err !== 1'b1) begin failures++; $display("[TB] FAIL ferr_hold: got %b expected 1", frame_err); end
        sendBit(1'b1);
        base = logCount;
        sendFrame(7'h3A, 1'b1, 1'b1);
        sendBit(1'b1);
        checks++; if (logCount - base !== 1) begin failures++; $display("[TB] FAIL ferr_next_count: got %0d expected 1", logCount - base); end
        checks++; if (dataLog[base % 16] !== 7'h3A) begin failures++; $display("[TB] FAIL ferr_next_data: got %h expected 3a", dataLog[base % 16]); end
        checks++; if (ferrLog[base % 16] !== 1'b0) begin failures++; $display("[TB] FAIL ferr_next_flag: got %b expected 0", ferrLog[base % 16]); end
        checks++; if (perrLog[base % 16] !== 1'b0) begin failures++; $display("[TB] FAIL ferr_next_perr: got %b expected 0", perrLog[base % 16]); end
    endtask

    task automatic test_false_start;
        int base = logCount;
        int busyHigh = 0;
        rx = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (busy) busyHigh++;
        end
        rx = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (busy) busyHigh++;
        end
        checks++; if (busyHigh == 0) begin failures++; $display("[TB] FAIL false_busy_pulse: got %0d busy clks expected >0", busyHigh); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL false_busy_end: got %b expected 0", busy); end
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++; if (logCount - base !== 0) begin failures++; $display("[TB] FAIL false_no_valid: got %0d expected 0", logCount - base); end
    endtask

    task automatic test_reset_mid_frame;
        int base = logCount;
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        rx = 1'b0;
        repeat (32) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy_after: got %b expected 0", busy); end
        reset = 1'b0;
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++; if (logCount - base !== 0) begin failures++; $display("[TB] FAIL midrst_no_valid: got %0d expected 0", logCount - base); end
        sendFrame(7'h3A, 1'b1, 1'b1);
        sendBit(1'b1);
        checks++; if (logCount - base !== 1) begin failures++; $display("[TB] FAIL midrst_next_count: got %0d expected 1", logCount - base); end
        checks++; if (dataLog[base % 16] !== 7'h3A) begin failures++; $display("[TB] FAIL midrst_next_data: got %h expected 3a", dataLog[base % 16]); end
        checks++; if (perrLog[base % 16] !== 1'b0 || ferrLog[base % 16] !== 1'b0) begin
            failures++; $display("[TB] FAIL midrst_next_flags: got p=%b f=%b expected p=0 f=0", perrLog[base % 16], ferrLog[base % 16]);
        end
    endtask

    task automatic test_back_to_back;
        int base = logCount;
        sendFrame(7'h00, 1'b1, 1'b1);
        sendFrame(7'h7F, 1'b0, 1'b1);
        sendBit(1'b1);
        checks++; if (logCount - base !== 2) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 2", logCount - base); end
        checks++; if (dataLog[base % 16] !== 7'h00) begin failures++; $display("[TB] FAIL b2b_data0: got %h expected 00", dataLog[base % 16]); end
        checks++; if (dataLog[(base + 1) % 16] !== 7'h7F) begin failures++; $display("[TB] FAIL b2b_data1: got %h expected 7f", dataLog[(base + 1) % 16]); end
        checks++; if ((perrLog[base % 16] | ferrLog[base % 16] | perrLog[(base + 1) % 16] | ferrLog[(base + 1) % 16]) !== 1'b0) begin
            failures++; $display("[TB] FAIL b2b_errors: got p0=%b f0=%b p1=%b f1=%b expected all 0",
                perrLog[base % 16], ferrLog[base % 16], perrLog[(base + 1) % 16], ferrLog[(base + 1) % 16]);
        end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_glitch;
        int base = logCount;
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b0);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        for (int i = 3; i < 7; i++) sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b1);
        checks++; if (logCount - base !== 1) begin failures++; $display("[TB] FAIL glitch_count: got %0d expected 1", logCount - base); end
        checks++; if (dataLog[base % 16] !== 7'h00) begin failures++; $display("[TB] FAIL glitch_data: got %h expected 00", dataLog[base % 16]); end
        checks++; if (perrLog[base % 16] !== 1'b0) begin failures++; $display("[TB] FAIL glitch_perr: got %b expected 0", perrLog[base % 16]); end
    endtask
`endif

    initial begin
        rx    = 1'b1;
        reset = 1'b1;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_frame_error();
        test_false_start();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef UART_RX_MAJORITY_EN
        test_glitch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
